// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: immediate + type + base word in,
// packed instruction with error flag and saturating error count out.
interface imm_encoder_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 valid_in;
  logic                 ready_out;
  logic [31:0]          imm_in;
  logic [2:0]           imm_type_in;
  logic [31:0]          base_instr_in;
  logic                 valid_out;
  logic                 ready_in;
  logic [31:0]          instr_out;
  logic                 err_out;
  logic [ERR_CNT_W-1:0] err_count_out;

  modport slave (
    input  valid_in, imm_in, imm_type_in, base_instr_in, ready_in,
    output ready_out, valid_out, instr_out, err_out, err_count_out
  );

  modport master (
    output valid_in, imm_in, imm_type_in, base_instr_in, ready_in,
    input  ready_out, valid_out, instr_out, err_out, err_count_out
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 holds the request and checks representability,
// S2 holds the packed RV32I instruction and error flag until downstream accepts.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input logic          clk_in,
  input logic          reset_in,
  imm_encoder_if.slave bus
);
  localparam logic [2:0] TY_NONE = 3'b000;
  localparam logic [2:0] TY_I    = 3'b001;
  localparam logic [2:0] TY_S    = 3'b010;
  localparam logic [2:0] TY_B    = 3'b011;
  localparam logic [2:0] TY_U    = 3'b100;
  localparam logic [2:0] TY_J    = 3'b101;
  localparam logic [2:0] TY_IL   = 3'b110;
  localparam logic [2:0] TY_I2   = 3'b111;

  logic                 v1, v2;
  logic [31:0]          imm1, base1;
  logic [2:0]           type1;
  logic                 err1;
  logic [31:0]          packed1;
  logic [31:0]          instr2;
  logic                 err2;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 s2_load, in_xfer, out_xfer;
  logic                 ext11, ext12, ext20;

  assign s2_load       = !v2 || bus.ready_in;
  assign bus.ready_out = !v1 || s2_load;
  assign in_xfer       = bus.valid_in && bus.ready_out;
  assign out_xfer      = v2 && bus.ready_in;

  assign bus.valid_out     = v2;
  assign bus.instr_out     = instr2;
  assign bus.err_out       = err2;
  assign bus.err_count_out = err_cnt;

  // Upper bits must be a pure sign extension of the highest encodable bit.
  assign ext11 = (imm1[31:11] == '0) || (imm1[31:11] == '1);
  assign ext12 = (imm1[31:12] == '0) || (imm1[31:12] == '1);
  assign ext20 = (imm1[31:20] == '0) || (imm1[31:20] == '1);

  always_comb begin
    err1    = 1'b0;
    packed1 = base1;
    case (type1)
      TY_NONE: err1 = |imm1;
      TY_I, TY_IL, TY_I2: begin
        err1           = !ext11;
        packed1[31:20] = imm1[11:0];
      end
      TY_S: begin
        err1           = !ext11;
        packed1[31:25] = imm1[11:5];
        packed1[11:7]  = imm1[4:0];
      end
      TY_B: begin
        err1           = imm1[0] || !ext12;
        packed1[31]    = imm1[12];
        packed1[30:25] = imm1[10:5];
        packed1[11:8]  = imm1[4:1];
        packed1[7]     = imm1[11];
      end
      TY_U: begin
        err1           = |imm1[11:0];
        packed1[31:12] = imm1[31:12];
      end
      TY_J: begin
        err1           = imm1[0] || !ext20;
        packed1[31]    = imm1[20];
        packed1[30:21] = imm1[10:1];
        packed1[20]    = imm1[11];
        packed1[19:12] = imm1[19:12];
      end
      default: ;
    endcase
  end

  // Request payload is only meaningful while v1 is set, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (in_xfer) begin
      imm1  <= bus.imm_in;
      type1 <= bus.imm_type_in;
      base1 <= bus.base_instr_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      instr2  <= '0;
      err2    <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (in_xfer) begin
        v1 <= 1'b1;
      end else if (s2_load) begin
        v1 <= 1'b0;
      end
      if (s2_load) begin
        v2 <= v1;
        if (v1) begin
          instr2 <= packed1;
          err2   <= err1;
        end
      end
      if (out_xfer && err2 && !(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Pipelined inverse of the decode-stage immediate extraction.
- Takes a 32-bit immediate, an immediate-type code and a base instruction word carrying the non-immediate fields (opcode, rd, rs1, rs2, funct3, funct7).
- Scatters the immediate into the RV32I bit positions for that type, producing a complete instruction word.
- Used by the instruction-memory preload / self-test generator path. Also flags immediates that the selected format cannot represent.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  upstream request valid.
- ready_out  output  1  block can accept a request this cycle.
- imm_in  input  32  immediate value, sign-extended form.
- imm_type_in  input  3  000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 I-load, 111 I.
- base_instr_in  input  32  instruction with the immediate bit positions don't-care.
- valid_out  output  1  encoded result valid.
- ready_in  input  1  downstream accepts result.
- instr_out  output  32  encoded instruction.
- err_out  output  1  immediate not representable; qualifies instr_out.
- err_count_out  output  ERR_CNT_W  number of erroneous results delivered, saturating.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge when valid and ready are both high. Input side uses valid_in/ready_out; output side uses valid_out/ready_in.
- Pipeline: two register stages, S1 (check) and S2 (pack/output). Latency with no stall is 2 cycles from input transfer to valid_out.
- Throughput is one item per cycle.
- Flow control:
  - S2 loads when !v2 || ready_in.
  - S1 advances when S2 loads.
  - ready_out = !v1 || S2-loads (combinational from ready_in).
  - No bubbles while both sides stream.
  - No item is dropped or duplicated under any ready_in pattern.
- Stage S1:
  - Registers imm_in, imm_type_in and base_instr_in on input transfer.
  - Computes the error bit, registered into S2 alongside the item.
- Error conditions by type:
  - 000: imm != 0.
  - 001/110/111: imm[31:11] not all-equal.
  - 010: same check as 001.
  - 011: imm[0] = 1, or imm[31:12] not all-equal.
  - 100: imm[11:0] != 0.
  - 101: imm[0] = 1, or imm[31:20] not all-equal.
- Packing, performed in stage S2; all instr_out bits not listed come from the registered base word:
  - 000: base unchanged.
  - I types (001/110/111): [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - U: [31:12] = imm[31:12].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
- On error, instr_out is still packed from the truncated bits and err_out = 1.
- Holding under stall: while valid_out && !ready_in, instr_out, err_out and valid_out hold stable.
- err_count_out:
  - Increments by 1 on each output transfer with err_out = 1.
  - Saturates at all-ones and never wraps.
- Reset (asynchronous, any time, including mid-stream):
  - v1 = 0, v2 = 0, valid_out = 0, instr_out = 0, err_out = 0, err_count_out = 0.
  - ready_out = 1 from the first cycle after reset deasserts.
  - All in-flight items are discarded.
- Data registers need not reset; valid bits and all outputs must.
- Round-trip property: decoding instr_out with the same type code reproduces imm_in whenever err_out = 0. For type 000 the decoded immediate is 0.

Test Plan:
- I-type: imm_in = 0xFFFFF800 (-2048), type 001, base 0x00000013, ready_in = 1 -> after 2 cycles instr_out = 0x80000013, err_out = 0. Then imm_in = 0x00000800 -> err_out = 1, err_count_out = 1.
- B-type: imm_in = 0xFFFFFFFE (-2), type 011, base 0x00000063 -> instr_out = 0xFE000FE3, err_out = 0. Then imm_in = 0x00000003 -> err_out = 1 (odd offset).
- J/U-type: J imm_in = 0x00000800, base 0x0000006F -> instr_out = 0x0010006F. U imm_in = 0x12345000, base 0x00000037 -> instr_out = 0x12345037. U imm_in = 0x12345001 -> err_out = 1.
- Backpressure: stream 8 items with valid_in held high while ready_in toggles 1,0,0,1,0,1,1,0,... -> all 8 delivered in order, no loss or duplication. Outputs stable during stall. ready_out = 0 only when both stages are full and ready_in = 0.
- Saturation: with ERR_CNT_W = 2, deliver 5 erroneous items -> err_count_out sequence 1, 2, 3, 3, 3.
- Reset mid-operation: assert reset_in asynchronously with both stages full and ready_in = 0 -> valid_out = 0, err_count_out = 0 immediately. After release, ready_out = 1 and the first new item appears 2 cycles after acceptance.
